// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and stall/flush controller for the five-stage in-order pipeline.
// A scoreboard shift register tracks in-flight writers from EXECUTE through WRITEBACK.
module pipeline_hazard_unit #(
  parameter int REGISTER_SIZE     = 5,
  parameter int PIPE_DEPTH        = 3,
  parameter int ALU_RESULT_STAGE  = 0,
  parameter int LOAD_RESULT_STAGE = 1,
  parameter int CNT_WIDTH         = 32,
  localparam int FW               = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic [REGISTER_SIZE-1:0] dec_rs1,
  input  logic [REGISTER_SIZE-1:0] dec_rs2,
  input  logic                     dec_rs1_used,
  input  logic                     dec_rs2_used,
  input  logic [REGISTER_SIZE-1:0] dec_rd,
  input  logic                     dec_rd_wr,
  input  logic                     dec_is_load,
  input  logic                     redirect,
  input  logic                     mem_ready,
  output logic                     f_to_d_enable,
  output logic                     d_to_e_enable,
  output logic                     e_to_m_enable,
  output logic                     bubble,
  output logic                     flush_fd,
  output logic [FW-1:0]            fwd_sel_a,
  output logic [FW-1:0]            fwd_sel_b,
  output logic [CNT_WIDTH-1:0]     stall_count,
  output logic [CNT_WIDTH-1:0]     flush_count
);

  typedef struct packed {
    logic          hazard;
    logic [FW-1:0] sel;
  } lookup_t;

  logic [PIPE_DEPTH-1:0]    sb_valid;
  logic [PIPE_DEPTH-1:0]    sb_load;
  logic [REGISTER_SIZE-1:0] sb_rd [PIPE_DEPTH];

  lookup_t look_a;
  lookup_t look_b;
  logic    hazard_stall;
  logic    accept_redirect;
  logic    new_valid;

  // Youngest matching entry decides: forward from it if its result exists yet, else stall.
  function automatic lookup_t lookup_src(input logic [REGISTER_SIZE-1:0] rs,
                                         input logic used);
    lookup_t res;
    logic    found;
    int      ready_stage;
    res   = '0;
    found = 1'b0;
    if (used && (rs != '0)) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (!found && sb_valid[k] && (sb_rd[k] == rs)) begin
          found       = 1'b1;
          ready_stage = sb_load[k] ? LOAD_RESULT_STAGE : ALU_RESULT_STAGE;
          if (k >= ready_stage) begin
            res.sel = FW'(k + 1);
          end else begin
            res.hazard = 1'b1;
          end
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    look_a = lookup_src(dec_rs1, dec_rs1_used);
    look_b = lookup_src(dec_rs2, dec_rs2_used);
  end

  assign fwd_sel_a    = look_a.sel;
  assign fwd_sel_b    = look_b.sel;
  assign hazard_stall = dec_valid & (look_a.hazard | look_b.hazard);

  // Memory back-pressure freezes everything; a data hazard holds fetch/decode and inserts a bubble.
  always_comb begin
    f_to_d_enable   = 1'b0;
    d_to_e_enable   = 1'b0;
    e_to_m_enable   = 1'b0;
    bubble          = 1'b0;
    flush_fd        = 1'b0;
    accept_redirect = 1'b0;
    if (!mem_ready) begin
      f_to_d_enable = 1'b0;
    end else if (hazard_stall) begin
      d_to_e_enable = 1'b1;
      e_to_m_enable = 1'b1;
      bubble        = 1'b1;
    end else begin
      f_to_d_enable   = 1'b1;
      d_to_e_enable   = 1'b1;
      e_to_m_enable   = 1'b1;
      bubble          = ~dec_valid;
      flush_fd        = redirect;
      accept_redirect = redirect;
    end
  end

  assign new_valid = dec_valid & dec_rd_wr & (dec_rd != '0) & ~bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid <= '0;
      sb_load  <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        sb_rd[k] <= '0;
      end
    end else if (e_to_m_enable) begin
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_load[k]  <= sb_load[k-1];
        sb_rd[k]    <= sb_rd[k-1];
      end
      sb_valid[0] <= new_valid;
      sb_load[0]  <= dec_is_load;
      sb_rd[0]    <= dec_rd;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!f_to_d_enable && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
      if (accept_redirect && (flush_count != '1)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule
